// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//
// Multi-ported register file with an attached pending-write scoreboard.
// Reads are combinational, and a same-cycle write is forwarded to the read
// port. Each register has a pending bit. A reserve sets the bit and a write
// clears it. A registered counter tracks how many bits are set.
//
// Parameters
//   WIDTH      data width of each register
//   REGSIZE    address width; depth is 2**REGSIZE
//   READPORTS  number of independent read ports (>= 1)
//   ZERO_REG   1: register 0 reads as 0 and is never written or reserved
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   writeEnable     commit writeValue to writeAddress
//   writeAddress    write target
//   writeValue      write data
//   reserveEnable   mark reserveAddress as pending
//   reserveAddress  register to reserve
//   flush           clear all pending marks at the next edge
//   readAddress     READPORTS packed addresses; port p = [p*REGSIZE +: REGSIZE]
//   readValue       READPORTS packed data; port p = [p*WIDTH +: WIDTH]
//   readBusy        bit p set when port p's register is pending
//   pendingCount    number of registers currently pending
module register_file_scoreboard #(
   parameter int WIDTH     = 32,
   parameter int REGSIZE   = 5,
   parameter int READPORTS = 2,
   parameter int ZERO_REG  = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           writeEnable,
   input  logic [REGSIZE-1:0]             writeAddress,
   input  logic [WIDTH-1:0]               writeValue,
   input  logic                           reserveEnable,
   input  logic [REGSIZE-1:0]             reserveAddress,
   input  logic                           flush,
   input  logic [READPORTS*REGSIZE-1:0]   readAddress,
   output logic [READPORTS*WIDTH-1:0]     readValue,
   output logic [READPORTS-1:0]           readBusy,
   output logic [REGSIZE:0]               pendingCount
);

   localparam int DEPTH = 1 << REGSIZE;

   logic [WIDTH-1:0]   r_regs [DEPTH];
   logic [DEPTH-1:0]   r_pending;
   logic [REGSIZE:0]   r_count;

   logic               w_wr_zero;
   logic               w_res_zero;
   logic               w_wr_eff;
   logic               w_res_eff;
   logic               w_set;
   logic               w_clr;
   logic [DEPTH-1:0]   w_pending_next;
   logic [REGSIZE:0]   w_count_next;

   // Register 0 is hard-wired only when ZERO_REG is enabled.
   assign w_wr_zero  = (ZERO_REG != 0) && (writeAddress == '0);
   assign w_res_zero = (ZERO_REG != 0) && (reserveAddress == '0);

   assign w_wr_eff  = writeEnable && !w_wr_zero;
   // flush drops a same-cycle reserve.
   assign w_res_eff = reserveEnable && !flush && !w_res_zero;

   // A bit turns on only when it was clear. This prevents a double count on
   // re-reserve.
   assign w_set = w_res_eff && !r_pending[reserveAddress];
   // A write clears its bit unless a same-cycle reserve on the same address
   // takes it over. In that case the new producer wins.
   assign w_clr = w_wr_eff && r_pending[writeAddress] &&
                  !(w_res_eff && (reserveAddress == writeAddress));

   always_comb begin
      w_pending_next = r_pending;
      if (flush) begin
         w_pending_next = '0;
      end else begin
         if (w_clr) w_pending_next[writeAddress] = 1'b0;
         if (w_set) w_pending_next[reserveAddress] = 1'b1;
      end
   end

   always_comb begin
      w_count_next = r_count;
      if (flush) begin
         w_count_next = '0;
      end else begin
         w_count_next = r_count + {{REGSIZE{1'b0}}, w_set}
                                - {{REGSIZE{1'b0}}, w_clr};
      end
   end

   // Storage array
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_eff) begin
         r_regs[writeAddress] <= writeValue;
      end
   end

   // Scoreboard state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= '0;
         r_count   <= '0;
      end else begin
         r_pending <= w_pending_next;
         r_count   <= w_count_next;
      end
   end

   assign pendingCount = r_count;

   // Read ports. Precedence is reset, then the zero register, then write
   // bypass, then storage.
   genvar gi;
   generate
      for (gi = 0; gi < READPORTS; gi++) begin : g_rd
         logic [REGSIZE-1:0] w_addr;
         logic [WIDTH-1:0]   w_val;
         logic               w_busy;

         assign w_addr = readAddress[gi*REGSIZE +: REGSIZE];

         always_comb begin
            w_val  = '0;
            w_busy = 1'b0;
            if (reset) begin
               w_val  = '0;
               w_busy = 1'b0;
            end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
               w_val  = '0;
               w_busy = 1'b0;
            end else if (writeEnable && (writeAddress == w_addr)) begin
               w_val  = writeValue;
               w_busy = 1'b0;
            end else begin
               w_val  = r_regs[w_addr];
               w_busy = r_pending[w_addr];
            end
         end

         assign readValue[gi*WIDTH +: WIDTH] = w_val;
         assign readBusy[gi]                 = w_busy;
      end
   endgenerate

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard
//
// Directed test of register_file_scoreboard with the default parameters
// (32-bit data, 32 registers, 2 read ports, zero register enabled).
// Expected values are hand-computed constants.
module tb_register_file_scoreboard;

   localparam int WIDTH     = 32;
   localparam int REGSIZE   = 5;
   localparam int READPORTS = 2;

   logic                         clk;
   logic                         reset;
   logic                         writeEnable;
   logic [REGSIZE-1:0]           writeAddress;
   logic [WIDTH-1:0]             writeValue;
   logic                         reserveEnable;
   logic [REGSIZE-1:0]           reserveAddress;
   logic                         flush;
   logic [READPORTS*REGSIZE-1:0] readAddress;
   logic [READPORTS*WIDTH-1:0]   readValue;
   logic [READPORTS-1:0]         readBusy;
   logic [REGSIZE:0]             pendingCount;

   int err_cnt = 0;
   int chk_cnt = 0;

   register_file_scoreboard #(
      .WIDTH    (WIDTH),
      .REGSIZE  (REGSIZE),
      .READPORTS(READPORTS),
      .ZERO_REG (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .writeEnable   (writeEnable),
      .writeAddress  (writeAddress),
      .writeValue    (writeValue),
      .reserveEnable (reserveEnable),
      .reserveAddress(reserveAddress),
      .flush         (flush),
      .readAddress   (readAddress),
      .readValue     (readValue),
      .readBusy      (readBusy),
      .pendingCount  (pendingCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [REGSIZE-1:0] a0, input logic [REGSIZE-1:0] a1);
      readAddress = {a1, a0};
   endtask

   task automatic idle();
      writeEnable   = 1'b0;
      reserveEnable = 1'b0;
      flush         = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      writeEnable    = 1'b0;
      writeAddress   = '0;
      writeValue     = '0;
      reserveEnable  = 1'b0;
      reserveAddress = '0;
      flush          = 1'b0;
      set_rd(5'd5, 5'd9);
      #2;
      check("rst_val0", readValue[31:0], 0);
      check("rst_val1", readValue[63:32], 0);
      check("rst_busy", readBusy, 0);
      check("rst_cnt", pendingCount, 0);
      tick();
      reset = 1'b0;

      // Write r5, then read it on both ports
      writeEnable = 1'b1; writeAddress = 5'd5; writeValue = 32'hDEADBEEF;
      tick();
      idle();
      set_rd(5'd5, 5'd5);
      #1;
      check("r5_p0", readValue[31:0], 32'hDEADBEEF);
      check("r5_p1", readValue[63:32], 32'hDEADBEEF);
      check("r5_busy", readBusy, 0);

      // Same-cycle bypass on port 1
      set_rd(5'd5, 5'd7);
      writeEnable = 1'b1; writeAddress = 5'd7; writeValue = 32'h1234;
      #1;
      check("byp_p1", readValue[63:32], 32'h1234);
      check("byp_p0", readValue[31:0], 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check("r7_held", readValue[63:32], 32'h1234);

      // Reserve r3, r9, r3 again
      reserveEnable = 1'b1; reserveAddress = 5'd3;
      tick();
      check("cnt_r3", pendingCount, 1);
      reserveAddress = 5'd9;
      tick();
      check("cnt_r9", pendingCount, 2);
      reserveAddress = 5'd3;
      tick();
      check("cnt_r3again", pendingCount, 2);
      idle();
      set_rd(5'd3, 5'd9);
      #1;
      check("busy_r3_r9", readBusy, 2'b11);
      writeEnable = 1'b1; writeAddress = 5'd3; writeValue = 32'h33;
      #1;
      check("byp_busy_r3", readBusy, 2'b10);
      check("byp_val_r3", readValue[31:0], 32'h33);
      tick();
      idle();
      #1;
      check("cnt_wr_r3", pendingCount, 1);
      check("busy_wr_r3", readBusy, 2'b10);
      check("val_r3", readValue[31:0], 32'h33);

      // Writing a non-pending register leaves the count alone
      writeEnable = 1'b1; writeAddress = 5'd12; writeValue = 32'hC0FFEE;
      tick();
      idle();
      check("cnt_wr_np", pendingCount, 1);

      // Same-cycle write and reserve of r4
      writeEnable = 1'b1; writeAddress = 5'd4; writeValue = 32'h55;
      reserveEnable = 1'b1; reserveAddress = 5'd4;
      tick();
      idle();
      set_rd(5'd4, 5'd12);
      #1;
      check("r4_val", readValue[31:0], 32'h55);
      check("r4_busy", readBusy, 2'b01);
      check("r4_cnt", pendingCount, 2);
      check("r12_val", readValue[63:32], 32'hC0FFEE);

      // Three registers pending, then flush with a reserve and a write
      reserveEnable = 1'b1; reserveAddress = 5'd6;
      tick();
      idle();
      check("cnt_three", pendingCount, 3);
      flush = 1'b1;
      reserveEnable = 1'b1; reserveAddress = 5'd10;
      writeEnable = 1'b1; writeAddress = 5'd2; writeValue = 32'hAA;
      tick();
      idle();
      set_rd(5'd10, 5'd2);
      #1;
      check("fl_cnt", pendingCount, 0);
      check("fl_busy", readBusy, 2'b00);
      check("fl_r2", readValue[63:32], 32'hAA);

      // Zero register: write and reserve ignored
      reserveEnable = 1'b1; reserveAddress = 5'd11;
      tick();
      check("cnt_r11", pendingCount, 1);
      writeEnable = 1'b1; writeAddress = 5'd0; writeValue = 32'hFF;
      reserveEnable = 1'b1; reserveAddress = 5'd0;
      set_rd(5'd0, 5'd11);
      #1;
      check("r0_comb", readValue[31:0], 0);
      tick();
      idle();
      #1;
      check("r0_val", readValue[31:0], 0);
      check("r0_busy", readBusy, 2'b10);
      check("r0_cnt", pendingCount, 1);

      // Asynchronous reset in the middle of a cycle
      set_rd(5'd5, 5'd11);
      #1;
      reset = 1'b1;
      #1;
      check("ar_val0", readValue[31:0], 0);
      check("ar_busy", readBusy, 0);
      check("ar_cnt", pendingCount, 0);
      // Writes and reserves during reset are ignored
      writeEnable = 1'b1; writeAddress = 5'd8; writeValue = 32'h77;
      reserveEnable = 1'b1; reserveAddress = 5'd8;
      tick();
      idle();
      reset = 1'b0;
      set_rd(5'd5, 5'd8);
      #1;
      check("post_r5", readValue[31:0], 0);
      check("post_r8", readValue[63:32], 0);
      check("post_busy", readBusy, 0);
      check("post_cnt", pendingCount, 0);

      // Normal operation resumes
      writeEnable = 1'b1; writeAddress = 5'd8; writeValue = 32'h77;
      tick();
      idle();
      #1;
      check("resume_r8", readValue[63:32], 32'h77);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register.
REQ-002 SHALL have parameter REGSIZE, default 5: address width; depth is 2^REGSIZE registers.
REQ-003 SHALL have parameter READPORTS, default 2: number of independent read ports, minimum 1.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 means register 0 reads 0 and is never written or reserved.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port writeEnable, input, 1 bit: commit writeValue to writeAddress.
REQ-008 SHALL have port writeAddress, input, REGSIZE bits: write target.
REQ-009 SHALL have port writeValue, input, WIDTH bits: write data.
REQ-010 SHALL have port reserveEnable, input, 1 bit: mark reserveAddress as pending.
REQ-011 SHALL have port reserveAddress, input, REGSIZE bits: register to reserve.
REQ-012 SHALL have port flush, input, 1 bit: synchronously clear all pending marks.
REQ-013 SHALL have port readAddress, input, READPORTS*REGSIZE bits: port p uses slice [p*REGSIZE +: REGSIZE].
REQ-014 SHALL have port readValue, output, READPORTS*WIDTH bits: port p uses slice [p*WIDTH +: WIDTH].
REQ-015 SHALL have port readBusy, output, READPORTS bits: bit p = 1 when port p's register is pending.
REQ-016 SHALL have port pendingCount, output, REGSIZE+1 bits: number of registers currently pending.

Function
REQ-017 Reads SHALL be combinational on every port, with no added clock latency.
REQ-018 Write SHALL update storage on the rising clk edge when writeEnable=1.
REQ-019 Bypass: when writeEnable=1 and writeAddress equals a port's address, that port SHALL return writeValue in the same cycle.
REQ-020 Under the bypass of REQ-019, that port's readBusy SHALL be 0.
REQ-021 With ZERO_REG=1, any access to address 0 SHALL return value 0 with readBusy=0.
REQ-022 With ZERO_REG=1, writes and reserves to address 0 SHALL be ignored.
REQ-023 A reserve SHALL set the pending bit of reserveAddress at the clk edge.
REQ-024 A write SHALL clear the pending bit of writeAddress at the clk edge.
REQ-025 When a write and a reserve target the same address in the same cycle, the data SHALL be written and the pending bit SHALL end at 1, because the new producer wins.
REQ-026 Reserving an already-pending register SHALL leave it pending, with no double count.
REQ-027 Writing a non-pending register SHALL store the data and leave pendingCount unchanged.
REQ-028 flush=1 SHALL clear all pending bits at the next clk edge.
REQ-029 flush SHALL override a reserve in the same cycle; the reserve is dropped.
REQ-030 A write in the same cycle as flush SHALL still store its data.
REQ-031 pendingCount SHALL be a registered counter updated each edge by +1 for a new pending bit, -1 for a cleared one, and net 0 when both happen.
REQ-032 pendingCount SHALL go to 0 on flush.
REQ-033 pendingCount SHALL always equal the population count of the pending bits.
REQ-034 pendingCount SHALL saturate at neither end; it can never exceed 2^REGSIZE, or 2^REGSIZE-1 with ZERO_REG=1.
REQ-035 Two or more read ports SHALL be able to read the same address simultaneously with identical results.

Reset
REQ-036 reset=1 SHALL immediately, without waiting for clk, clear all registers to 0, all pending bits to 0 and pendingCount to 0.
REQ-037 While reset=1, readValue SHALL be 0 and readBusy SHALL be 0 on every port, regardless of the addresses presented.
REQ-038 While reset=1, writes, reserves and flush SHALL be ignored.
REQ-039 Assertion of reset mid-stream SHALL discard all state.
REQ-040 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-041 Bench SHALL cover: write 0xDEADBEEF to r5, then read r5 on both ports next cycle -> both return 0xDEADBEEF, readBusy=0.
REQ-042 Bench SHALL cover: write 0x1234 to r7 while port 1 reads r7 in the same cycle -> port 1 returns 0x1234 combinationally; r7 holds 0x1234 next cycle.
REQ-043 Bench SHALL cover: reserve r3, then r9, then r3 again -> pendingCount 1, 2, 2; read r3 -> readBusy=1; write r3 -> pendingCount=1, readBusy(r3)=0.
REQ-044 Bench SHALL cover: same-cycle write and reserve of r4 with value 0x55 -> r4 reads 0x55, readBusy=1, pendingCount +1.
REQ-045 Bench SHALL cover: three registers pending, then flush together with a reserve of r10 and a write of 0xAA to r2 -> pendingCount=0, r10 not pending, r2 reads 0xAA.
REQ-046 Bench SHALL cover: with ZERO_REG=1, write 0xFF to r0 and reserve r0 -> r0 reads 0, readBusy=0, pendingCount unchanged; then assert reset asynchronously mid-clock-cycle -> all reads 0 and pendingCount 0 before the next edge.
